// File: rtl/nios2_mul_sequencer.sv
// Issue/capture sequencer around the Nios II 32x32 multiplier cell.
// Define NIOS2_MUL_HIGH_EN to build the 4-pass high-word mode.
module nios2_mul_sequencer #(
    parameter int CELL_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    input  logic        req_high,
    output logic [31:0] mul_src1,
    output logic [31:0] mul_src2,
    input  logic [31:0] mul_result,
    output logic        rsp_valid,
    output logic [31:0] rsp_result,
    input  logic        rsp_ready
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    localparam logic [2:0] LAT = 3'(CELL_LAT);

    state_t      state_q, state_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [31:0] rsp_q, rsp_d;
    logic [2:0]  cnt_q, cnt_d;

    assign req_ready  = (state_q == IDLE) && !reset;
    assign rsp_valid  = (state_q == DONE);
    assign rsp_result = rsp_q;
    assign mul_src1   = op1_q;
    assign mul_src2   = op2_q;

`ifdef NIOS2_MUL_HIGH_EN
    logic        hi_q, hi_d;
    logic [1:0]  pass_q, pass_d, pass_n;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] part, acc_sum;

    assign pass_n = pass_q + 2'd1;

    // Partial product weight: lo*lo, then the two cross terms, then hi*hi.
    always_comb begin
        part = '0;
        unique case (pass_q)
            2'd0:       part = {32'h0, mul_result};
            2'd1, 2'd2: part = {16'h0, mul_result, 16'h0};
            2'd3:       part = {mul_result, 32'h0};
        endcase
    end

    assign acc_sum = acc_q + part;

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q   <= 1'b0;
            pass_q <= 2'd0;
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
        end else begin
            hi_q   <= hi_d;
            pass_q <= pass_d;
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
        end
    end
`else
    logic unused_req_high;
    assign unused_req_high = req_high;
`endif

    always_comb begin
        state_d = state_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        rsp_d   = rsp_q;
        cnt_d   = cnt_q;
`ifdef NIOS2_MUL_HIGH_EN
        hi_d    = hi_q;
        pass_d  = pass_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
`endif
        unique case (state_q)
            IDLE: begin
                op1_d = '0;
                op2_d = '0;
                if (req_valid) begin
                    state_d = WAIT;
                    cnt_d   = LAT;
                    op1_d   = req_src1;
                    op2_d   = req_src2;
`ifdef NIOS2_MUL_HIGH_EN
                    hi_d    = req_high;
                    pass_d  = 2'd0;
                    a_d     = req_src1;
                    b_d     = req_src2;
                    acc_d   = '0;
                    if (req_high) begin
                        op1_d = {16'h0, req_src1[15:0]};
                        op2_d = {16'h0, req_src2[15:0]};
                    end
`endif
                end
            end
            WAIT: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    state_d = DONE;
                    rsp_d   = mul_result;
                    op1_d   = '0;
                    op2_d   = '0;
`ifdef NIOS2_MUL_HIGH_EN
                    if (hi_q) begin
                        acc_d = acc_sum;
                        rsp_d = acc_sum[63:32];
                        if (pass_q != 2'd3) begin
                            // Next pass operands go out on this capture edge.
                            state_d = WAIT;
                            rsp_d   = rsp_q;
                            cnt_d   = LAT;
                            pass_d  = pass_n;
                            op1_d   = {16'h0, pass_n[0] ? a_q[31:16] : a_q[15:0]};
                            op2_d   = {16'h0, pass_n[1] ? b_q[31:16] : b_q[15:0]};
                        end
                    end
`endif
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op1_q   <= '0;
            op2_q   <= '0;
            rsp_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            rsp_q   <= rsp_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_nios2_mul_sequencer.sv
// Scoreboard bench for nios2_mul_sequencer at CELL_LAT 1 and 3.
// Honours NIOS2_MUL_HIGH_EN when the build defines it.
module tb_nios2_mul_sequencer;

`ifdef NIOS2_MUL_HIGH_EN
    localparam bit HIGH_EN = 1'b1;
`else
    localparam bit HIGH_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        hi;
        logic [31:0] res;
        logic [31:0] e0;
        logic [31:0] lat;
    } txn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    endtask

    function automatic logic [31:0] model_res(input logic [31:0] a, input logic [31:0] b,
                                              input logic hi);
        logic [63:0] p;
        p = {32'h0, a} * {32'h0, b};
        return hi ? p[63:32] : p[31:0];
    endfunction

    function automatic logic [63:0] model_ops(input logic [31:0] a, input logic [31:0] b,
                                              input logic hi, input int pass);
        logic [15:0] ah, bh;
        if (!hi) return {a, b};
        ah = (pass % 2 == 1) ? a[31:16] : a[15:0];
        bh = (pass >= 2) ? b[31:16] : b[15:0];
        return {16'h0, ah, 16'h0, bh};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int L = (g == 0) ? 1 : 3;

        logic        reset, req_valid, req_ready, req_high;
        logic        rsp_valid, rsp_ready;
        logic [31:0] req_src1, req_src2, mul_src1, mul_src2;
        logic [31:0] mul_result, rsp_result;
        logic        bp_hold, rand_mode, done;
        logic [31:0] pipe [L];
        logic [31:0] cyc = '0;
        txn_t        exp_q[$];
        logic        seen = 1'b0;
        logic        hs_prev = 1'b0;

        nios2_mul_sequencer #(.CELL_LAT(L)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .req_valid (req_valid),
            .req_ready (req_ready),
            .req_src1  (req_src1),
            .req_src2  (req_src2),
            .req_high  (req_high),
            .mul_src1  (mul_src1),
            .mul_src2  (mul_src2),
            .mul_result(mul_result),
            .rsp_valid (rsp_valid),
            .rsp_result(rsp_result),
            .rsp_ready (rsp_ready)
        );

        // Multiplier cell: low word of the product after L edges.
        always @(posedge clk) begin
            pipe[0] <= mul_src1 * mul_src2;
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
            cyc <= cyc + 32'd1;
        end
        assign mul_result = pipe[L-1];

        always @(posedge clk) begin
            #1;
            rsp_ready = bp_hold ? 1'b0 : (rand_mode ? 1'($urandom_range(0, 1)) : 1'b1);
        end

        always @(negedge clk) begin
            txn_t t;
            int   k;
            if (reset) begin
                exp_q.delete();
                seen = 1'b0;
                hs_prev = 1'b0;
            end else begin
                if (hs_prev) begin
                    check("rsp_valid_drop", 64'(rsp_valid), 64'd0);
                    check("req_ready_after_rsp", 64'(req_ready), 64'd1);
                end
                hs_prev = 1'b0;
                if (exp_q.size() == 0) begin
                    check("no_spurious_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    t = exp_q[0];
                    if (rsp_valid) begin
                        if (!seen) begin
                            check("latency", 64'(cyc - t.e0), 64'(t.lat));
                            seen = 1'b1;
                        end
                        check("rsp_result", 64'(rsp_result), 64'(t.res));
                        check("req_ready_in_done", 64'(req_ready), 64'd0);
                        if (rsp_ready) begin
                            void'(exp_q.pop_front());
                            seen = 1'b0;
                            hs_prev = 1'b1;
                        end
                    end else if (cyc >= t.e0) begin
                        k = int'(cyc - t.e0);
                        check("cell_operands", {mul_src1, mul_src2},
                              model_ops(t.a, t.b, t.hi, k / (L + 1)));
                        check("req_ready_busy", 64'(req_ready), 64'd0);
                    end
                end
                if (req_ready) check("idle_operands", {mul_src1, mul_src2}, 64'd0);
                if (req_valid && req_ready) begin
                    t.a   = req_src1;
                    t.b   = req_src2;
                    t.hi  = req_high & HIGH_EN;
                    t.res = model_res(req_src1, req_src2, t.hi);
                    t.e0  = cyc + 32'd1;
                    t.lat = t.hi ? 32'(4 * (L + 1)) : 32'(L + 1);
                    exp_q.push_back(t);
                end
            end
        end

        task automatic tick();
            @(posedge clk);
            #1;
        endtask

        task automatic send(input logic [31:0] a, input logic [31:0] b, input logic hi);
            int n = 0;
            req_src1 = a;
            req_src2 = b;
            req_high = hi;
            req_valid = 1'b1;
            while (!req_ready && n < 400) begin
                tick();
                n++;
            end
            check("req_accept_timeout", 64'(req_ready), 64'd1);
            tick();
            req_valid = 1'b0;
        endtask

        task automatic wait_rsp();
            int n = 0;
            while (!rsp_valid && n < 400) begin
                tick();
                n++;
            end
            check("rsp_timeout", 64'(rsp_valid), 64'd1);
        endtask

        task automatic wait_idle();
            int n = 0;
            while (!(req_ready && exp_q.size() == 0) && n < 400) begin
                tick();
                n++;
            end
            check("idle_timeout", {62'd0, req_ready, exp_q.size() == 0}, 64'd3);
        endtask

        initial begin
            logic [31:0] ra, rb;
            done = 1'b0;
            reset = 1'b1;
            req_valid = 1'b0;
            req_src1 = '0;
            req_src2 = '0;
            req_high = 1'b0;
            bp_hold = 1'b0;
            rand_mode = 1'b0;
            rsp_ready = 1'b1;
            repeat (3) tick();
            check("rst_req_ready", 64'(req_ready), 64'd0);
            check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            check("rst_rsp_result", 64'(rsp_result), 64'd0);
            check("rst_mul_src", {mul_src1, mul_src2}, 64'd0);
            reset = 1'b0;
            tick();
            check("rel_req_ready", 64'(req_ready), 64'd1);

            send(32'h0001_0003, 32'h0002_0005, 1'b0);
            wait_idle();
            send(32'h0001_0003, 32'h0002_0005, 1'b1);
            wait_idle();
            send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
            wait_idle();
            send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
            wait_idle();
            send(32'd7, 32'd6, 1'b0);
            wait_idle();

            // Stalled consumer with a competing request held on the input.
            bp_hold = 1'b1;
            send(32'h0000_1234, 32'h0000_5678, 1'b0);
            wait_rsp();
            req_src1 = 32'h0000_ABCD;
            req_src2 = 32'h0000_0011;
            req_valid = 1'b1;
            repeat (5) tick();
            bp_hold = 1'b0;
            send(32'h0000_ABCD, 32'h0000_0011, 1'b0);
            wait_idle();

            // Reset while the cell is still working on a request.
            send(32'h0000_0055, 32'h0000_0066, 1'b0);
            reset = 1'b1;
            tick();
            check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
            check("midrst_mul_src", {mul_src1, mul_src2}, 64'd0);
            tick();
            reset = 1'b0;
            tick();
            check("midrst_req_ready", 64'(req_ready), 64'd1);
            repeat (8) tick();

            rand_mode = 1'b1;
            repeat (30) begin
                ra = $urandom();
                rb = $urandom();
                if ($urandom_range(0, 3) == 0) ra = ra & 32'h0000_FFFF;
                if ($urandom_range(0, 3) == 0) rb = rb | 32'hFFFF_0000;
                send(ra, rb, 1'($urandom_range(0, 1)));
            end
            wait_idle();
            rand_mode = 1'b0;
            done = 1'b1;
        end
    end

    initial begin
        int n = 0;
        while (!(gen_dut[0].done && gen_dut[1].done) && n < 50000) begin
            @(posedge clk);
            n++;
        end
        check("bench_done", {62'd0, gen_dut[0].done, gen_dut[1].done}, 64'd3);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
